// File: rtl/custom_axil_slave.sv
// AXI4-Lite slave: four scratch regs, version word, write counter.
// Ports: ACLK/ARESETN, S_AXI_AW*/W*/B* write path, S_AXI_AR*/R* read path.
module custom_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] C_VERSION = 32'h0001_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE, R_RESP
  } r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DW-1:0] regs [4];
  logic [DW-1:0] wcount;
  logic [2:0]    aw_idx_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic          ready_en;

  logic          aw_hs, w_hs, ar_hs;
  logic          commit;
  logic [2:0]    c_idx;
  logic [DW-1:0] c_data;
  logic [SW-1:0] c_strb;
  logic [2:0]    rd_idx;
  logic [DW-1:0] rd_word;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  assign S_AXI_AWREADY = ready_en &&
    (w_state == W_IDLE || w_state == W_HAVE_D);
  assign S_AXI_WREADY  = ready_en &&
    (w_state == W_IDLE || w_state == W_HAVE_A);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);
  assign S_AXI_RVALID  = (r_state == R_RESP);

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Commit operands come from live inputs or the latched half.
  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    c_idx  = aw_idx_q;
    c_data = wdata_q;
    c_strb = wstrb_q;
    unique case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_idx  = S_AXI_AWADDR[4:2];
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end else if (aw_hs) begin
          w_next = W_HAVE_A;
        end else if (w_hs) begin
          w_next = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_data = S_AXI_WDATA;
          c_strb = S_AXI_WSTRB;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          w_next = W_RESP;
          commit = 1'b1;
          c_idx  = S_AXI_AWADDR[4:2];
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state     <= W_IDLE;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wcount      <= '0;
      S_AXI_BRESP <= OKAY;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        S_AXI_BRESP <= (c_idx[2:1] == 2'b11) ? SLVERR : OKAY;
        if (!c_idx[2]) begin
          wcount <= wcount + 1'b1;
          for (int i = 0; i < SW; i++)
            if (c_strb[i])
              regs[c_idx[1:0]][8*i +: 8] <= c_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    rd_word = '0;
    unique case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_word = regs[rd_idx[1:0]];
      3'd4:    rd_word = C_VERSION;
      3'd5:    rd_word = wcount;
      default: rd_word = '0;
    endcase
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read data sampled from pre-edge state, so a same-edge write is not seen.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        S_AXI_RDATA <= rd_word;
        S_AXI_RRESP <= (rd_idx[2:1] == 2'b11) ? SLVERR : OKAY;
      end
    end
  end

endmodule

// File: doc/custom_axil_slave.md
CUSTOM_AXIL_SLAVE -- requirements
Module: custom_axil_slave

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 Parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 word slots).
REQ-003 Parameter C_VERSION, default 32'h0001_0000, constant returned at slot 4.
REQ-004 ACLK  in  1  single clock; all logic rising-edge.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 S_AXI_AWADDR  in  5  write address; S_AXI_AWPROT  in  3  ignored.
REQ-007 S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write address handshake.
REQ-008 S_AXI_WDATA  in  32 / S_AXI_WSTRB  in  4  write data, byte enables.
REQ-009 S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write data handshake.
REQ-010 S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
REQ-011 S_AXI_ARADDR  in  5 / S_AXI_ARPROT  in  3 (ignored) / S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read address.
REQ-012 S_AXI_RDATA  out  32 / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.

Function
REQ-013 Word index = ADDR[4:2]; ADDR[1:0] ignored.
REQ-014 Slots 0-3: read/write scratch registers REG0..REG3.
REQ-015 Slot 4: read-only C_VERSION; writes ignored, BRESP OKAY.
REQ-016 Slot 5: read-only WCOUNT, 32-bit count of committed writes to slots 0-3, wraps 0xFFFF_FFFF -> 0.
REQ-017 Slots 6-7: unmapped; reads return 0 with RRESP SLVERR (2'b10), writes ignored with BRESP SLVERR.
REQ-018 Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_HAVE_A (AWREADY=0, WREADY=1), W_HAVE_D (AWREADY=1, WREADY=0), W_RESP (both READY=0, BVALID=1).
REQ-019 W_IDLE: AW+W same cycle -> W_RESP; AW only -> W_HAVE_A (address latched); W only -> W_HAVE_D (data/strobe latched).
REQ-020 W_HAVE_A on W handshake, W_HAVE_D on AW handshake -> W_RESP.
REQ-021 Register update commits on the clock edge entering W_RESP; only bytes with WSTRB[i]=1 change; WCOUNT increments by 1 for slots 0-3 regardless of strobe value.
REQ-022 W_RESP: BVALID and BRESP held stable until BREADY=1; on that edge -> W_IDLE; next AW/W accepted no earlier than following cycle.
REQ-023 Read FSM states: R_IDLE (ARREADY=1, RVALID=0), R_RESP (ARREADY=0, RVALID=1).
REQ-024 AR handshake in R_IDLE: RDATA/RRESP captured from pre-edge register values, -> R_RESP; latency one cycle from AR handshake to RVALID.
REQ-025 R_RESP: RDATA, RRESP, RVALID held stable until RREADY=1; then -> R_IDLE.
REQ-026 Read and write channels independent; simultaneous read and write commit to same slot on one edge: read returns old value.
REQ-027 Maximum one outstanding write and one outstanding read; no VALID output depends combinationally on any input.

Reset
REQ-028 ARESETN=0 asynchronously clears REG0..REG3, WCOUNT, latched address/data, all FSMs to IDLE.
REQ-029 During reset: AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0.
REQ-030 READY outputs assert no earlier than first rising edge after ARESETN deasserts.
REQ-031 Reset mid-transaction discards the pending transaction with no register update and no response.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, read back each -> RDATA 0x1..0x4, all RESP OKAY, WCOUNT read = 4.
REQ-033 W presented 3 cycles before AW to 0x4, data 0xAABBCCDD, WSTRB 4'b0101 over 0x11223344 -> REG1 = 0x11BB33DD; AW-before-W gives identical result.
REQ-034 BREADY held 0 for 5 cycles after write -> BVALID stays 1, no AW/W accepted, single commit; RREADY held 0 -> RDATA stable.
REQ-035 Read 0x10 -> 0x0001_0000 OKAY; read 0x18 -> 0x0 SLVERR; write 0x1C -> BRESP SLVERR, no register or WCOUNT change.
REQ-036 AR and final W handshake to 0x0 same edge, REG0=0x5, WDATA=0x9 -> RDATA 0x5, subsequent read 0x9.
REQ-037 ARESETN pulsed low while in W_HAVE_A -> all outputs 0 immediately, REG0..REG3 read 0, no BVALID issued.
